// File: rtl/sccb_init_sequencer.sv
// Power-up and register-initialisation sequencer for an SCCB camera sensor: walks a command
// table issuing writes, verify-reads and delays through the SCCB driver with NACK retries.
module sccb_init_sequencer #(
    parameter int unsigned ROM_DEPTH       = 73,
    parameter int unsigned REG_ADDR_W      = 8,
    parameter int unsigned POWERUP_CYCLES  = 1000,
    parameter int unsigned CAM_RESET_CYCLE = 5,
    parameter int unsigned MAX_RETRY       = 3,
    localparam int unsigned ENTRY_W        = 2 + REG_ADDR_W + 8,
    localparam int unsigned IDX_W          = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart,
    output logic [IDX_W-1:0]      rom_addr,
    input  logic [ENTRY_W-1:0]    rom_data,
    output logic                  drv_start,
    output logic                  drv_rw,
    output logic [REG_ADDR_W-1:0] drv_addr,
    output logic [7:0]            drv_wdata,
    input  logic                  drv_load_comp,
    input  logic                  drv_task_comp,
    input  logic                  drv_nack,
    input  logic [7:0]            drv_rdata,
    output logic                  cam_reset,
    output logic [7:0]            read_data,
    output logic                  read_valid,
    output logic                  init_done,
    output logic                  init_error,
    output logic                  verify_fail,
    output logic [IDX_W-1:0]      entry_idx
);
    localparam int unsigned PWR_W   = $clog2(POWERUP_CYCLES + 1);
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned DLY_W   = REG_ADDR_W + 8;

    typedef enum logic [1:0] {OpWrite, OpRead, OpDelay, OpEnd} op_e;

    typedef enum logic [2:0] {
        StReset, StFetch, StDecode, StLoad, StWait, StDelay, StDone, StError
    } state_e;

    state_e                state_q, state_d;
    logic [PWR_W-1:0]      pwr_cnt_q, pwr_cnt_d;
    logic [IDX_W-1:0]      entry_idx_q, entry_idx_d;
    logic [RETRY_W-1:0]    retry_cnt_q, retry_cnt_d;
    logic [DLY_W-1:0]      dly_cnt_q, dly_cnt_d;
    logic                  rw_q, rw_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic                  cam_reset_q, cam_reset_d;
    logic [7:0]            read_data_q, read_data_d;
    logic                  read_valid_q, read_valid_d;
    logic                  verify_fail_q, verify_fail_d;
    logic                  advance;
    op_e                   op;

    assign op = op_e'(rom_data[ENTRY_W-1 -: 2]);

    always_comb begin
        state_d       = state_q;
        pwr_cnt_d     = pwr_cnt_q;
        entry_idx_d   = entry_idx_q;
        retry_cnt_d   = retry_cnt_q;
        dly_cnt_d     = dly_cnt_q;
        rw_d          = rw_q;
        addr_d        = addr_q;
        data_d        = data_q;
        cam_reset_d   = cam_reset_q;
        read_data_d   = read_data_q;
        read_valid_d  = 1'b0;
        verify_fail_d = verify_fail_q;
        advance       = 1'b0;

        unique case (state_q)
            StReset: begin
                pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
                if (pwr_cnt_d == PWR_W'(CAM_RESET_CYCLE)) cam_reset_d = 1'b1;
                if (pwr_cnt_d == PWR_W'(POWERUP_CYCLES)) begin
                    state_d     = StFetch;
                    entry_idx_d = '0;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                rw_d   = (op == OpRead);
                addr_d = rom_data[8 +: REG_ADDR_W];
                data_d = rom_data[7:0];
                unique case (op)
                    OpWrite, OpRead: state_d = StLoad;
                    OpDelay: begin
                        dly_cnt_d = rom_data[DLY_W-1:0];
                        state_d   = StDelay;
                    end
                    OpEnd: state_d = StDone;
                endcase
            end
            StLoad: if (drv_load_comp) state_d = StWait;
            StWait: begin
                if (drv_task_comp) begin
                    if (drv_nack) begin
                        if (retry_cnt_q < RETRY_W'(MAX_RETRY)) begin
                            retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                            state_d     = StLoad;
                        end else begin
                            state_d = StError;
                        end
                    end else begin
                        retry_cnt_d = '0;
                        advance     = 1'b1;
                        if (rw_q) begin
                            read_data_d  = drv_rdata;
                            read_valid_d = 1'b1;
                            if (drv_rdata != data_q) verify_fail_d = 1'b1;
                        end
                    end
                end
            end
            // Zero and one both spend a single cycle here; N>1 spends N cycles.
            StDelay: begin
                if (dly_cnt_q <= DLY_W'(1)) advance = 1'b1;
                else dly_cnt_d = dly_cnt_q - DLY_W'(1);
            end
            StDone, StError: ;
            default: state_d = StReset;
        endcase

        if (advance) begin
            if (entry_idx_q == IDX_W'(ROM_DEPTH - 1)) begin
                state_d = StDone;
            end else begin
                entry_idx_d = entry_idx_q + IDX_W'(1);
                state_d     = StFetch;
            end
        end

        // Restart overrides any driver handshake seen in the same cycle.
        if (restart) begin
            state_d       = StReset;
            pwr_cnt_d     = '0;
            entry_idx_d   = '0;
            retry_cnt_d   = '0;
            cam_reset_d   = 1'b0;
            read_valid_d  = 1'b0;
            verify_fail_d = 1'b0;
        end
    end

    always_ff @(negedge clk) begin
        if (!rst) begin
            state_q       <= StReset;
            pwr_cnt_q     <= '0;
            entry_idx_q   <= '0;
            retry_cnt_q   <= '0;
            dly_cnt_q     <= '0;
            rw_q          <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            cam_reset_q   <= 1'b0;
            read_data_q   <= '0;
            read_valid_q  <= 1'b0;
            verify_fail_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pwr_cnt_q     <= pwr_cnt_d;
            entry_idx_q   <= entry_idx_d;
            retry_cnt_q   <= retry_cnt_d;
            dly_cnt_q     <= dly_cnt_d;
            rw_q          <= rw_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            cam_reset_q   <= cam_reset_d;
            read_data_q   <= read_data_d;
            read_valid_q  <= read_valid_d;
            verify_fail_q <= verify_fail_d;
        end
    end

    assign rom_addr    = entry_idx_q;
    assign entry_idx   = entry_idx_q;
    assign drv_start   = (state_q == StLoad);
    assign drv_rw      = rw_q;
    assign drv_addr    = addr_q;
    assign drv_wdata   = data_q;
    assign cam_reset   = cam_reset_q;
    assign read_data   = read_data_q;
    assign read_valid  = read_valid_q;
    assign init_done   = (state_q == StDone);
    assign init_error  = (state_q == StError);
    assign verify_fail = verify_fail_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Bench for sccb_init_sequencer: command tables are walked by a sequential reference model
// that predicts every driver request, gap, read-back and final flag.
module tb_sccb_init_sequencer;
    localparam int unsigned PWR_A   = 1000;
    localparam int unsigned PWR_B   = 20;
    localparam int unsigned DEPTH_A = 73;
    localparam int unsigned DEPTH_B = 4;
    localparam int unsigned MAXR    = 3;
    localparam logic [1:0] OP_WR = 2'd0, OP_RD = 2'd1, OP_DLY = 2'd2, OP_END = 2'd3;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [7:0]  data;
        int          nacks;
        logic [7:0]  rd;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, sel_b, restart, load_comp, task_comp, nack;
    logic [7:0] rdata;

    logic [6:0]  rom_addr_a, idx_a;
    logic [17:0] rom_data_a;
    logic [7:0]  addr_a, wdata_a, rdo_a;
    logic        start_a, rw_a, cam_a, rv_a, done_a, err_a, vf_a;
    logic [1:0]  rom_addr_b, idx_b;
    logic [25:0] rom_data_b;
    logic [15:0] addr_b;
    logic [7:0]  wdata_b, rdo_b;
    logic        start_b, rw_b, cam_b, rv_b, done_b, err_b, vf_b;

    logic [17:0] rom_a [DEPTH_A];
    logic [25:0] rom_b [DEPTH_B];
    ent_t        tbl [$];
    int          total, bad;

    sccb_init_sequencer #(
        .ROM_DEPTH(DEPTH_A), .REG_ADDR_W(8), .POWERUP_CYCLES(PWR_A),
        .CAM_RESET_CYCLE(5), .MAX_RETRY(MAXR)
    ) dut_a (
        .clk(clk), .rst(rst_a), .restart(restart), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .drv_start(start_a), .drv_rw(rw_a), .drv_addr(addr_a), .drv_wdata(wdata_a),
        .drv_load_comp(load_comp), .drv_task_comp(task_comp), .drv_nack(nack),
        .drv_rdata(rdata), .cam_reset(cam_a), .read_data(rdo_a), .read_valid(rv_a),
        .init_done(done_a), .init_error(err_a), .verify_fail(vf_a), .entry_idx(idx_a)
    );

    sccb_init_sequencer #(
        .ROM_DEPTH(DEPTH_B), .REG_ADDR_W(16), .POWERUP_CYCLES(PWR_B),
        .CAM_RESET_CYCLE(5), .MAX_RETRY(MAXR)
    ) dut_b (
        .clk(clk), .rst(rst_b), .restart(restart), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .drv_start(start_b), .drv_rw(rw_b), .drv_addr(addr_b), .drv_wdata(wdata_b),
        .drv_load_comp(load_comp), .drv_task_comp(task_comp), .drv_nack(nack),
        .drv_rdata(rdata), .cam_reset(cam_b), .read_data(rdo_b), .read_valid(rv_b),
        .init_done(done_b), .init_error(err_b), .verify_fail(vf_b), .entry_idx(idx_b)
    );

    // Registered table: word appears one clock after the address.
    always @(negedge clk) begin
        rom_data_a <= rom_a[rom_addr_a];
        rom_data_b <= rom_b[rom_addr_b];
    end

    logic        o_start, o_rw, o_cam, o_rv, o_done, o_err, o_vf;
    logic [15:0] o_addr;
    logic [7:0]  o_wdata, o_rdo, o_idx;
    assign o_start = sel_b ? start_b : start_a;
    assign o_rw    = sel_b ? rw_b : rw_a;
    assign o_cam   = sel_b ? cam_b : cam_a;
    assign o_rv    = sel_b ? rv_b : rv_a;
    assign o_done  = sel_b ? done_b : done_a;
    assign o_err   = sel_b ? err_b : err_a;
    assign o_vf    = sel_b ? vf_b : vf_a;
    assign o_addr  = sel_b ? addr_b : {8'h00, addr_a};
    assign o_wdata = sel_b ? wdata_b : wdata_a;
    assign o_rdo   = sel_b ? rdo_b : rdo_a;
    assign o_idx   = sel_b ? {6'd0, idx_b} : {1'b0, idx_a};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input logic [1:0] op, input logic [15:0] addr,
                                input logic [7:0] data, input int nacks, input logic [7:0] rd);
        ent_t e;
        e.op = op; e.addr = addr; e.data = data; e.nacks = nacks; e.rd = rd;
        return e;
    endfunction

    task automatic load_rom();
        for (int i = 0; i < int'(DEPTH_A); i++) rom_a[i] = '0;
        for (int i = 0; i < int'(DEPTH_B); i++) rom_b[i] = '0;
        foreach (tbl[i]) begin
            if (sel_b) rom_b[i] = {tbl[i].op, tbl[i].addr, tbl[i].data};
            else rom_a[i] = {tbl[i].op, tbl[i].addr[7:0], tbl[i].data};
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_start"}, o_start, 0);
        chk({tag, "_cam"}, o_cam, 0);
        chk({tag, "_rvalid"}, o_rv, 0);
        chk({tag, "_rdata"}, o_rdo, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_err"}, o_err, 0);
        chk({tag, "_vfail"}, o_vf, 0);
        chk({tag, "_idx"}, o_idx, 0);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk);
        restart = 1'b0;
        chk("restart_cam", o_cam, 0);
        chk("restart_start", o_start, 0);
        chk("restart_done", o_done, 0);
        chk("restart_err", o_err, 0);
        chk("restart_vfail", o_vf, 0);
    endtask

    task automatic wait_start(input int budget, output int n);
        n = 0;
        while (!o_start && n < budget) begin @(posedge clk); n++; end
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!o_done && n < budget) begin @(posedge clk); n++; end
    endtask

    // Called at the edge where drv_start is seen; returns one edge after task_comp.
    task automatic respond(input logic nk, input logic [7:0] rd, input int lat_l, input int lat_t);
        repeat (lat_l) @(posedge clk);
        chk("start_held", o_start, 1);
        load_comp = 1'b1;
        @(posedge clk);
        load_comp = 1'b0;
        chk("start_low_in_wait", o_start, 0);
        repeat (lat_t) @(posedge clk);
        task_comp = 1'b1; nack = nk; rdata = rd;
        @(posedge clk);
        task_comp = 1'b0; nack = 1'b0; rdata = 8'($urandom);
    endtask

    // Reference walk: pending is the cycle count until the next request (or DONE).
    task automatic walk(input int start_pending);
        int pending, n, d, att, last_idx;
        bit vf, err, ended, abort;
        logic nk;
        logic [7:0] rd;
        logic [15:0] eaddr;
        pending = start_pending; vf = 0; err = 0; ended = 0; abort = 0; last_idx = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            if (err || ended || abort) break;
            last_idx = i;
            if (tbl[i].op == OP_END) begin
                ended = 1;
            end else if (tbl[i].op == OP_DLY) begin
                d = sel_b ? int'({tbl[i].addr, tbl[i].data}) : int'({tbl[i].addr[7:0], tbl[i].data});
                if (d == 0) d = 1;
                pending += 2 + d;
            end else begin
                att = 0;
                eaddr = sel_b ? tbl[i].addr : {8'h00, tbl[i].addr[7:0]};
                forever begin
                    wait_start(pending + 20, n);
                    chk("start_gap", n, pending);
                    if (!o_start) begin abort = 1; break; end
                    chk("entry_idx", o_idx, i);
                    chk("drv_rw", o_rw, (tbl[i].op == OP_RD));
                    chk("drv_addr", o_addr, eaddr);
                    chk("drv_wdata", o_wdata, tbl[i].data);
                    nk = (att < tbl[i].nacks);
                    rd = nk ? 8'($urandom) : tbl[i].rd;
                    respond(nk, rd, $urandom_range(0, 2), $urandom_range(0, 3));
                    if (nk && att == int'(MAXR)) begin
                        chk("error_flag", o_err, 1);
                        chk("error_start", o_start, 0);
                        chk("error_no_done", o_done, 0);
                        repeat (4) @(posedge clk);
                        chk("error_start_hold", o_start, 0);
                        chk("error_idx_frozen", o_idx, i);
                        chk("error_flag_hold", o_err, 1);
                        err = 1;
                        break;
                    end
                    if (nk) begin
                        att++;
                        pending = 0;
                    end else begin
                        if (tbl[i].op == OP_RD) begin
                            chk("read_valid_pulse", o_rv, 1);
                            chk("read_data", o_rdo, rd);
                            @(posedge clk);
                            chk("read_valid_low", o_rv, 0);
                            if (rd != tbl[i].data) vf = 1;
                            pending = 1;
                        end else begin
                            pending = 2;
                        end
                        break;
                    end
                end
            end
        end
        if (abort || err) return;
        if (!ended) pending = (pending < 2) ? 0 : pending - 2;
        wait_done(pending + 20, n);
        chk("done_gap", n, pending);
        chk("init_done", o_done, 1);
        chk("no_error", o_err, 0);
        chk("verify_fail", o_vf, vf);
        chk("final_idx", o_idx, last_idx);
        chk("done_start_low", o_start, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        total = 0; bad = 0;
        rst_a = 0; rst_b = 0; sel_b = 0; restart = 0;
        load_comp = 0; task_comp = 0; nack = 0; rdata = 0;
        repeat (3) @(posedge clk);
        check_reset_state("por");

        // Three writes and END straight out of reset.
        tbl.delete();
        for (int i = 0; i < 3; i++) tbl.push_back(mk(OP_WR, 16'($urandom), 8'($urandom), 0, 0));
        tbl.push_back(mk(OP_END, 0, 0, 0, 0));
        load_rom();
        rst_a = 1'b1;
        repeat (4) @(posedge clk);
        chk("cam_reset_before_5", o_cam, 0);
        @(posedge clk);
        chk("cam_reset_at_5", o_cam, 1);
        walk(PWR_A + 2 - 5);

        // NACK retries; second entry needs the retry counter cleared after the first.
        tbl.delete();
        tbl.push_back(mk(OP_WR, 16'h0012, 8'h34, 2, 0));
        tbl.push_back(mk(OP_WR, 16'h0056, 8'h78, 3, 0));
        tbl.push_back(mk(OP_RD, 16'h009a, 8'hbc, 1, 8'hbc));
        tbl.push_back(mk(OP_END, 0, 0, 0, 0));
        load_rom();
        pulse_restart();
        walk(PWR_A + 2);

        // Four NACKs in a row end in ERROR.
        tbl.delete();
        tbl.push_back(mk(OP_WR, 16'h0011, 8'h22, 0, 0));
        tbl.push_back(mk(OP_WR, 16'h0033, 8'h44, 4, 0));
        tbl.push_back(mk(OP_END, 0, 0, 0, 0));
        load_rom();
        pulse_restart();
        walk(PWR_A + 2);

        // Verify-read mismatch is flagged but the sequence completes.
        tbl.delete();
        tbl.push_back(mk(OP_RD, 16'h000a, 8'h76, 0, 8'h73));
        tbl.push_back(mk(OP_WR, 16'h000b, 8'h01, 0, 0));
        tbl.push_back(mk(OP_END, 0, 0, 0, 0));
        load_rom();
        pulse_restart();
        walk(PWR_A + 2);

        // rst mid-run with restart also asserted; then delays of 0 and 16.
        rst_a = 1'b0; restart = 1'b1;
        @(posedge clk);
        check_reset_state("rst_mid");
        restart = 1'b0;
        tbl.delete();
        tbl.push_back(mk(OP_WR, 16'h0001, 8'h10, 0, 0));
        tbl.push_back(mk(OP_DLY, 16'h0000, 8'h00, 0, 0));
        tbl.push_back(mk(OP_WR, 16'h0002, 8'h20, 0, 0));
        tbl.push_back(mk(OP_DLY, 16'h0000, 8'h10, 0, 0));
        tbl.push_back(mk(OP_WR, 16'h0003, 8'h30, 0, 0));
        tbl.push_back(mk(OP_END, 0, 0, 0, 0));
        load_rom();
        @(posedge clk);
        rst_a = 1'b1;
        walk(PWR_A + 2);

        // Randomized tables.
        for (int r = 0; r < 6; r++) begin
            int len;
            tbl.delete();
            len = $urandom_range(3, 7);
            for (int k = 0; k < len; k++) begin
                int s, nk;
                logic [7:0] dd, flip;
                s = $urandom_range(0, 9);
                nk = $urandom_range(0, 19);
                nk = (nk == 0) ? 4 : nk % 4;
                dd = 8'($urandom);
                flip = 8'h01 << $urandom_range(0, 7);
                if (s < 5) tbl.push_back(mk(OP_WR, 16'($urandom), dd, nk, 0));
                else if (s < 8)
                    tbl.push_back(mk(OP_RD, 16'($urandom), dd, nk,
                                     ($urandom_range(0, 1) == 0) ? dd : (dd ^ flip)));
                else tbl.push_back(mk(OP_DLY, 16'h0000, 8'($urandom_range(0, 20)), 0, 0));
            end
            tbl.push_back(mk(OP_END, 0, 0, 0, 0));
            load_rom();
            pulse_restart();
            walk(PWR_A + 2);
        end

        // 16-bit register addresses, table without END.
        rst_a = 1'b0;
        sel_b = 1'b1;
        tbl.delete();
        tbl.push_back(mk(OP_RD, 16'h1234, 8'h55, 0, 8'h54));
        tbl.push_back(mk(OP_WR, 16'hbeef, 8'ha5, 1, 0));
        tbl.push_back(mk(OP_WR, 16'h3a00, 8'h5a, 0, 0));
        tbl.push_back(mk(OP_WR, 16'h300f, 8'hc3, 0, 0));
        load_rom();
        @(posedge clk);
        rst_b = 1'b1;
        walk(PWR_B + 2);

        // Restart coincident with task_comp while waiting on entry 1.
        pulse_restart();
        wait_start(PWR_B + 30, n);
        chk("b_first_gap", n, PWR_B + 2);
        respond(1'b0, 8'h54, 0, 0);
        chk("b_vfail_set", o_vf, 1);
        wait_start(20, n);
        chk("b_second_start", o_start, 1);
        load_comp = 1'b1;
        @(posedge clk);
        load_comp = 1'b0;
        @(posedge clk);
        task_comp = 1'b1; restart = 1'b1;
        @(posedge clk);
        task_comp = 1'b0; restart = 1'b0;
        chk("b_rs_start", o_start, 0);
        chk("b_rs_cam", o_cam, 0);
        chk("b_rs_vfail", o_vf, 0);
        chk("b_rs_done", o_done, 0);
        chk("b_rs_err", o_err, 0);
        walk(PWR_B + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
